// File: rtl/i2c_slave_responder_pkg.sv
// Shared I2C target definitions: FSM state encoding and reserved addresses.
package package_i2c;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } t_slave_states;

    localparam logic [6:0] c_i2c_general_call = 7'h00;

endpackage

// File: rtl/i2c_slave_responder_bus_monitor.sv
// I2C line conditioner: synchronizes raw SCL/SDA and flags SCL edges plus
// START/STOP conditions, all derived from the synchronized values.
module i2c_bus_monitor #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_pipe;
    logic [STAGES-1:0] sda_pipe;
    logic              scl_dly;
    logic              sda_dly;
    logic              scl_sync;

    // Idle bus is high, so resetting to 1 avoids phantom edges after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_dly  <= 1'b1;
            sda_dly  <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[STAGES-2:0], scl};
            sda_pipe <= {sda_pipe[STAGES-2:0], sda};
            scl_dly  <= scl_pipe[STAGES-1];
            sda_dly  <= sda_pipe[STAGES-1];
        end
    end

    assign scl_sync  = scl_pipe[STAGES-1];
    assign sda_sync  = sda_pipe[STAGES-1];
    assign scl_rise  = scl_sync & ~scl_dly;
    assign scl_fall  = ~scl_sync & scl_dly;
    assign start_det = scl_sync & sda_dly & ~sda_sync;
    assign stop_det  = scl_sync & ~sda_dly & sda_sync;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target endpoint: address match, register pointer, write/read bursts
// onto a synchronous register-file port; drives SDA low only.
module i2c_slave_responder
    import package_i2c::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h33,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_reg_addr,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_data,
    output logic       o_rd_req,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);

    t_slave_states state;
    t_slave_states state_next;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       sda_sync;

    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic [7:0] wr_data;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic       rd_req;
    logic       rd_load;
    logic       master_nack;

    logic [7:0] byte_in;
    logic       last_bit;
    logic       addr_hit;
    logic       in_ack;
    logic       rx_shift;
    logic       tx_shift;
    logic       ack_take;
    logic       ack_done;
    logic       rd_start;
    logic       wr_fire;

    i2c_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_monitor (
        .clk       (i_clk),
        .rst       (i_rst),
        .scl       (i_scl),
        .sda       (i_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_sync  (sda_sync)
    );

    assign byte_in  = {shift[6:0], sda_sync};
    assign last_bit = (bit_cnt == 3'd7);
    assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) && (byte_in[7:1] != c_i2c_general_call);
    assign in_ack   = state inside {ADDR_ACK, REG_ACK, WDATA_ACK};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                ADDR:      if (rx_shift && last_bit) state_next = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  if (ack_done) state_next = shift[0] ? RDATA : REG;
                REG:       if (rx_shift && last_bit) state_next = REG_ACK;
                REG_ACK:   if (ack_done) state_next = WDATA;
                WDATA:     if (wr_fire) state_next = WDATA_ACK;
                WDATA_ACK: if (ack_done) state_next = WDATA;
                RDATA:     if (tx_shift && last_bit) state_next = RDATA_ACK;
                RDATA_ACK: if (scl_fall) state_next = master_nack ? WAIT_STOP : RDATA;
                default:   state_next = state;
            endcase
        end
    end

    // ACK states use sda_oe as their phase: the first fall drives, the second releases.
    always_comb begin
        rx_shift = 1'b0;
        tx_shift = 1'b0;
        ack_take = 1'b0;
        ack_done = 1'b0;
        rd_start = 1'b0;
        wr_fire  = 1'b0;
        if (!start_det && !stop_det) begin
            rx_shift = scl_rise && (state inside {ADDR, REG, WDATA});
            tx_shift = scl_fall && (state == RDATA);
            ack_take = scl_fall && in_ack && !sda_oe;
            ack_done = scl_fall && in_ack && sda_oe;
            wr_fire  = rx_shift && last_bit && (state == WDATA);
            rd_start = (ack_done && (state == ADDR_ACK) && shift[0])
                     || (scl_fall && (state == RDATA_ACK) && !master_nack);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            wr_data     <= '0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            wr_valid    <= 1'b0;
            rd_req      <= 1'b0;
            rd_load     <= 1'b0;
            master_nack <= 1'b0;
        end else begin
            wr_valid <= wr_fire;
            rd_req   <= rd_start;
            rd_load  <= rd_req;
            if (wr_valid) begin
                ptr <= ptr + 8'd1;
            end
            if (stop_det || start_det) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (stop_det) begin
                    busy <= 1'b0;
                end
            end else begin
                if (rx_shift) begin
                    shift   <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit && state == ADDR) begin
                        busy <= addr_hit;
                    end
                    if (last_bit && state == REG) begin
                        ptr <= byte_in;
                    end
                end
                if (wr_fire) begin
                    wr_data <= byte_in;
                end
                if (ack_take) begin
                    sda_oe <= 1'b1;
                end
                if (ack_done || rd_start) begin
                    sda_oe  <= 1'b0;
                    bit_cnt <= '0;
                end
                // Read data arrives one cycle after the request; drive its MSB at once.
                if (rd_load) begin
                    shift  <= i_rd_data;
                    sda_oe <= ~i_rd_data[7];
                end
                if (tx_shift) begin
                    shift   <= {shift[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        sda_oe <= 1'b0;
                        ptr    <= ptr + 8'd1;
                    end else begin
                        sda_oe <= ~shift[6];
                    end
                end
                if (scl_rise && state == RDATA_ACK) begin
                    master_nack <= sda_sync;
                end
            end
        end
    end

    assign o_sda_oe   = sda_oe;
    assign o_reg_addr = ptr;
    assign o_wr_valid = wr_valid;
    assign o_wr_data  = wr_data;
    assign o_rd_req   = rd_req;
    assign o_busy     = busy;

endmodule
